// File: rtl/pad_step_scanner.sv
// Tempo-driven 8-step scanner: produces the pad decoder step index, the hit
// status of the current step, and one-cycle advance/wrap pulses.
module pad_step_scanner #(
  parameter int DIV_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Run,
  input  logic             StepReq,
  input  logic             Dir,
  input  logic [2:0]       Len,
  input  logic [DIV_W-1:0] Period,
  input  logic             PadWr,
  input  logic [2:0]       PadSel,
  input  logic             PadVal,
  output logic [2:0]       Step,
  output logic             Tick,
  output logic             Wrap,
  output logic             Hit,
  output logic             Busy
);

  typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_t;

  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div, div_nxt;
  logic [7:0]       pattern;
  logic             adv;
  logic             adv_wrap;
  logic [2:0]       step_nxt;

  // Returns {wrap, next_step}; a step beyond Len re-enters the loop via the wrap rule.
  function automatic logic [3:0] next_step(input logic [2:0] cur,
                                           input logic [2:0] len,
                                           input logic       dir);
    logic [3:0] r;
    if (!dir) begin
      if (cur >= len) r = {1'b1, 3'd0};
      else            r = {1'b0, cur + 3'd1};
    end else begin
      if (cur == 3'd0 || cur > len) r = {1'b1, len};
      else                          r = {1'b0, cur - 3'd1};
    end
    return r;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= STOP;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      STOP:    if (Run)  state_nxt = RUN;
      RUN:     if (!Run) state_nxt = STOP;
      default: state_nxt = STOP;
    endcase
  end

  // StepReq only counts while stopped and not simultaneously starting a run.
  always_comb begin
    adv     = 1'b0;
    div_nxt = '0;
    case (state)
      STOP: adv = !Run && StepReq;
      RUN: begin
        adv     = (div >= Period);
        div_nxt = (!Run || adv) ? '0 : div + DIV_ONE;
      end
      default: adv = 1'b0;
    endcase
    {adv_wrap, step_nxt} = next_step(Step, Len, Dir);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div     <= '0;
      Step    <= 3'd0;
      pattern <= 8'd0;
      Tick    <= 1'b0;
      Wrap    <= 1'b0;
    end else begin
      div  <= div_nxt;
      Tick <= adv;
      Wrap <= adv && adv_wrap;
      if (adv)   Step            <= step_nxt;
      if (PadWr) pattern[PadSel] <= PadVal;
    end
  end

  assign Busy = (state == RUN);
  assign Hit  = pattern[Step];

endmodule
